// File: rtl/multi_alarm_bank_pkg.sv
// ----------------------------------------------------------------------------
// clock_pkg
// Shared types and constants for the multi-slot alarm bank.
//   slot_state_t : per-slot alarm state (OFF, ARMED, RINGING, SNOOZED)
//   HR24_MAX     : largest legal 24h hour
//   MIN_MAX      : largest legal minute
//   SECS_PER_MIN : seconds in a minute, used to size the snooze countdown
// ----------------------------------------------------------------------------
package clock_pkg;

    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RINGING = 2'd2,
        ST_SNOOZED = 2'd3
    } slot_state_t;

    localparam int HR24_MAX     = 23;
    localparam int MIN_MAX      = 59;
    localparam int SECS_PER_MIN = 60;

endpackage

// File: rtl/multi_alarm_bank_slot.sv
// ----------------------------------------------------------------------------
// alarm_slot
// One alarm slot: stored 24h time, slot FSM, ring/snooze counters.
//   clk, reset_n   : clock, asynchronous active-low reset
//   i_sec_tick     : 1 Hz strobe (drives ring and snooze counters)
//   i_match_tick   : sec_tick at second 0 with a legal normalised time
//   i_curr24       : current hour, 24h
//   i_curr_min     : current minute
//   i_wr           : validated write addressed to this slot
//   i_wr_hr/min    : time to store on write
//   i_wr_enable    : 1 = ARMED after write, 0 = OFF
//   i_snooze       : snooze button pulse
//   i_dismiss      : dismiss button pulse
//   o_state        : current FSM state (also the debug view of the slot)
//
// Valid/ready note: this block has no back-pressure. Every input is a
// single-cycle qualifier sampled on the clock edge where it is high; there
// is no ready, and an event is never held over to a later cycle.
// ----------------------------------------------------------------------------
module alarm_slot
    import clock_pkg::*;
#(
    parameter int SNOOZE_MIN = 9,
    parameter int RING_SECS  = 60,
    parameter int MAX_SNOOZE = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_sec_tick,
    input  logic        i_match_tick,
    input  logic [4:0]  i_curr24,
    input  logic [5:0]  i_curr_min,
    input  logic        i_wr,
    input  logic [4:0]  i_wr_hr,
    input  logic [5:0]  i_wr_min,
    input  logic        i_wr_enable,
    input  logic        i_snooze,
    input  logic        i_dismiss,
    output slot_state_t o_state
);

    localparam int SNZ_W = $clog2(SNOOZE_MIN * SECS_PER_MIN + 1);
    localparam int SC_W  = $clog2(MAX_SNOOZE + 1);

    localparam logic [SNZ_W-1:0] SNZ_LOAD = SNZ_W'(SNOOZE_MIN * SECS_PER_MIN);
    localparam logic [SNZ_W-1:0] SNZ_ONE  = SNZ_W'(1);
    localparam logic [SC_W-1:0]  SC_MAX   = SC_W'(MAX_SNOOZE);
    localparam logic [SC_W-1:0]  SC_ONE   = SC_W'(1);
    localparam logic [7:0]       RING_LIM = 8'(RING_SECS);

    slot_state_t      r_state,     w_state_nxt;
    logic [4:0]       r_hr,        w_hr_nxt;
    logic [5:0]       r_min,       w_min_nxt;
    logic [7:0]       r_ring_cnt,  w_ring_nxt;
    logic [SNZ_W-1:0] r_snz_cnt,   w_snz_nxt;
    logic [SC_W-1:0]  r_snz_count, w_count_nxt;

    logic             w_match;
    logic [7:0]       w_ring_inc;

    assign w_match    = i_match_tick && (i_curr24 == r_hr) && (i_curr_min == r_min);
    assign w_ring_inc = r_ring_cnt + 8'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_OFF;
            r_hr        <= '0;
            r_min       <= '0;
            r_ring_cnt  <= '0;
            r_snz_cnt   <= '0;
            r_snz_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_hr        <= w_hr_nxt;
            r_min       <= w_min_nxt;
            r_ring_cnt  <= w_ring_nxt;
            r_snz_cnt   <= w_snz_nxt;
            r_snz_count <= w_count_nxt;
        end
    end

    // Priority: write > dismiss > snooze > auto-silence / snooze expiry > match.
    always_comb begin
        w_state_nxt = r_state;
        w_hr_nxt    = r_hr;
        w_min_nxt   = r_min;
        w_ring_nxt  = r_ring_cnt;
        w_snz_nxt   = r_snz_cnt;
        w_count_nxt = r_snz_count;

        if (i_wr) begin
            w_state_nxt = i_wr_enable ? ST_ARMED : ST_OFF;
            w_hr_nxt    = i_wr_hr;
            w_min_nxt   = i_wr_min;
            w_ring_nxt  = '0;
            w_snz_nxt   = '0;
            w_count_nxt = '0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    w_state_nxt = ST_OFF;
                end
                ST_ARMED: begin
                    if (w_match) begin
                        w_state_nxt = ST_RINGING;
                        w_ring_nxt  = '0;
                        w_count_nxt = '0;
                    end
                end
                ST_RINGING: begin
                    if (i_dismiss) begin
                        w_state_nxt = ST_ARMED;
                    end else if (i_snooze) begin
                        // Once the snooze allowance is used up, snooze behaves as dismiss.
                        if (r_snz_count < SC_MAX) begin
                            w_state_nxt = ST_SNOOZED;
                            w_count_nxt = r_snz_count + SC_ONE;
                            w_snz_nxt   = SNZ_LOAD;
                        end else begin
                            w_state_nxt = ST_ARMED;
                        end
                    end else if (i_sec_tick) begin
                        w_ring_nxt = w_ring_inc;
                        if (w_ring_inc == RING_LIM) begin
                            w_state_nxt = ST_ARMED;
                        end
                    end
                end
                ST_SNOOZED: begin
                    if (i_dismiss) begin
                        w_state_nxt = ST_ARMED;
                    end else if (i_sec_tick) begin
                        w_snz_nxt = r_snz_cnt - SNZ_ONE;
                        // Counter hits zero on this tick: resume ringing.
                        if (r_snz_cnt == SNZ_ONE) begin
                            w_state_nxt = ST_RINGING;
                            w_ring_nxt  = '0;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_OFF;
                end
            endcase
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/multi_alarm_bank.sv
// ----------------------------------------------------------------------------
// multi_alarm_bank
// N independent alarm slots beside the timekeeper.
//   clk, reset_n      : clock, asynchronous active-low reset
//   sec_tick          : 1 Hz strobe aligned with the timekeeper update
//   AM_mode           : 1 = curr_hr is 12h with curr_pm, 0 = 24h
//   curr_hr/min/sec   : current time
//   curr_pm           : PM flag (12h mode only)
//   wr_en/idx/hr/min  : slot programming port (24h time)
//   wr_enable         : arm (1) or disable (0) the written slot
//   snooze_btn        : snoozes every RINGING slot
//   dismiss_btn       : dismisses every RINGING or SNOOZED slot
//   wr_err            : one-cycle pulse, cycle after a rejected write
//   armed/ringing/snoozed : per-slot state decodes
//   alarm_buzzer      : OR of ringing
// ----------------------------------------------------------------------------
module multi_alarm_bank
    import clock_pkg::*;
#(
    parameter int  N_ALARMS   = 4,
    parameter int  SNOOZE_MIN = 9,
    parameter int  RING_SECS  = 60,
    parameter int  MAX_SNOOZE = 3,
    localparam int IDX_W      = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                sec_tick,
    input  logic                AM_mode,
    input  logic [5:0]          curr_hr,
    input  logic [5:0]          curr_min,
    input  logic [5:0]          curr_sec,
    input  logic                curr_pm,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [4:0]          wr_hr,
    input  logic [5:0]          wr_min,
    input  logic                wr_enable,
    input  logic                snooze_btn,
    input  logic                dismiss_btn,
    output logic                wr_err,
    output logic [N_ALARMS-1:0] armed,
    output logic [N_ALARMS-1:0] ringing,
    output logic [N_ALARMS-1:0] snoozed,
    output logic                alarm_buzzer
);

    logic [4:0]  w_curr24;
    logic        w_time_ok;
    logic        w_match_tick;
    logic        w_wr_ok;
    logic        r_wr_err;
    slot_state_t w_state [N_ALARMS];

    // Normalise the current hour to 24h; an illegal hour never matches.
    always_comb begin
        w_curr24  = 5'd0;
        w_time_ok = 1'b0;
        if (!AM_mode) begin
            w_time_ok = (curr_hr <= 6'(HR24_MAX));
            w_curr24  = curr_hr[4:0];
        end else begin
            w_time_ok = (curr_hr != 6'd0) && (curr_hr <= 6'd12);
            if (curr_hr == 6'd12) begin
                w_curr24 = curr_pm ? 5'd12 : 5'd0;
            end else if (curr_pm) begin
                w_curr24 = curr_hr[4:0] + 5'd12;
            end else begin
                w_curr24 = curr_hr[4:0];
            end
        end
    end

    assign w_match_tick = sec_tick && (curr_sec == 6'd0) && w_time_ok;

    assign w_wr_ok = wr_en
                  && (wr_hr <= 5'(HR24_MAX))
                  && (wr_min <= 6'(MIN_MAX))
                  && ({{(32-IDX_W){1'b0}}, wr_idx} < 32'(N_ALARMS));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= wr_en && !w_wr_ok;
        end
    end

    assign wr_err = r_wr_err;

    for (genvar g = 0; g < N_ALARMS; g++) begin : g_slot
        alarm_slot #(
            .SNOOZE_MIN (SNOOZE_MIN),
            .RING_SECS  (RING_SECS),
            .MAX_SNOOZE (MAX_SNOOZE)
        ) u_slot (
            .clk          (clk),
            .reset_n      (reset_n),
            .i_sec_tick   (sec_tick),
            .i_match_tick (w_match_tick),
            .i_curr24     (w_curr24),
            .i_curr_min   (curr_min),
            .i_wr         (w_wr_ok && (wr_idx == IDX_W'(g))),
            .i_wr_hr      (wr_hr),
            .i_wr_min     (wr_min),
            .i_wr_enable  (wr_enable),
            .i_snooze     (snooze_btn),
            .i_dismiss    (dismiss_btn),
            .o_state      (w_state[g])
        );

        assign armed[g]   = (w_state[g] == ST_ARMED);
        assign ringing[g] = (w_state[g] == ST_RINGING);
        assign snoozed[g] = (w_state[g] == ST_SNOOZED);
    end

    assign alarm_buzzer = |ringing;

endmodule
